// File: rtl/memory_requester.sv
// CPU-side initiator for the DDR2 controller send/receive handshake: takes one
// cache-line request, drives it to the controller and returns the captured line.
module memory_requester #(
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int CNT_W          = 16
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_req_valid,
    output logic         o_req_ready,
    input  logic         i_req_we,
    input  logic [22:0]  i_req_addr,
    input  logic [15:0]  i_req_strb,
    input  logic [127:0] i_req_data,
    output logic         o_rsp_valid,
    input  logic         i_rsp_ready,
    output logic         o_rsp_we,
    output logic [127:0] o_rsp_data,
    output logic         o_en,
    output logic         o_we,
    output logic [22:0]  o_addr,
    output logic [15:0]  o_strb,
    output logic [127:0] o_data,
    input  logic         i_rcv,
    input  logic         i_done,
    input  logic [127:0] i_data,
    output logic         o_ack,
    output logic         o_busy,
    output logic         o_timeout
);

    typedef enum logic [1:0] {IDLE, SEND, WAIT, RSP} state_e;

    localparam logic [CNT_W-1:0] TO_LIMIT = CNT_W'(TIMEOUT_CYCLES);

    state_e         state_q;
    logic           en_q, we_q, ack_q, rsp_valid_q, rsp_we_q, timeout_q;
    logic [22:0]    addr_q;
    logic [15:0]    strb_q;
    logic [127:0]   data_q, rsp_data_q;
    logic           rcv_low_q, done_seen_q, done_cmp_q;
    logic [CNT_W-1:0] cnt_q;

    logic           active, capture, cnt_run;
    logic           rcv_low_d, done_cmp_d;
    logic [CNT_W-1:0] cnt_d;

    // Completion flags are evaluated with this cycle's inputs so RSP is entered
    // on the same edge that observes the last of the two handshake releases.
    always_comb begin
        active     = (state_q == SEND) || (state_q == WAIT);
        capture    = active && i_done && !done_seen_q;
        rcv_low_d  = rcv_low_q || ((state_q == WAIT) && !i_rcv);
        done_cmp_d = done_cmp_q || (ack_q && !i_done);
        cnt_run    = active && !done_seen_q && (cnt_q != '1);
        cnt_d      = cnt_run ? cnt_q + CNT_W'(1) : cnt_q;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= IDLE;
            en_q        <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            strb_q      <= '0;
            data_q      <= '0;
            ack_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_we_q    <= 1'b0;
            rsp_data_q  <= '0;
            timeout_q   <= 1'b0;
            rcv_low_q   <= 1'b0;
            done_seen_q <= 1'b0;
            done_cmp_q  <= 1'b0;
            cnt_q       <= '0;
        end else begin
            cnt_q <= cnt_d;
            if ((TIMEOUT_CYCLES != 0) && cnt_run && (cnt_d == TO_LIMIT))
                timeout_q <= 1'b1;
            unique case (state_q)
                IDLE: begin
                    if (i_req_valid) begin
                        we_q        <= i_req_we;
                        addr_q      <= i_req_addr;
                        strb_q      <= i_req_strb;
                        data_q      <= i_req_data;
                        en_q        <= 1'b1;
                        rcv_low_q   <= 1'b0;
                        done_seen_q <= 1'b0;
                        done_cmp_q  <= 1'b0;
                        cnt_q       <= '0;
                        state_q     <= SEND;
                    end
                end
                SEND, WAIT: begin
                    if (capture) begin
                        rsp_data_q  <= i_data;
                        ack_q       <= 1'b1;
                        done_seen_q <= 1'b1;
                    end else if (ack_q && !i_done) begin
                        ack_q      <= 1'b0;
                        done_cmp_q <= 1'b1;
                    end
                    rcv_low_q <= rcv_low_d;
                    if (state_q == SEND) begin
                        if (i_rcv) begin
                            en_q    <= 1'b0;
                            state_q <= WAIT;
                        end
                    end else if (rcv_low_d && done_cmp_d) begin
                        rsp_valid_q <= 1'b1;
                        rsp_we_q    <= we_q;
                        state_q     <= RSP;
                    end
                end
                RSP: begin
                    if (i_rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign o_req_ready = (state_q == IDLE);
    assign o_busy      = (state_q != IDLE);
    assign o_en        = en_q;
    assign o_we        = we_q;
    assign o_addr      = addr_q;
    assign o_strb      = strb_q;
    assign o_data      = data_q;
    assign o_ack       = ack_q;
    assign o_rsp_valid = rsp_valid_q;
    assign o_rsp_we    = rsp_we_q;
    assign o_rsp_data  = rsp_data_q;
    assign o_timeout   = timeout_q;

endmodule

// File: tb/tb_memory_requester.sv
// Bench for memory_requester: event-time reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_memory_requester;

    localparam int TO  = 8;
    localparam int INF = 1 << 30;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req_valid = 1'b0, req_we = 1'b0;
    logic [22:0]  req_addr = '0;
    logic [15:0]  req_strb = '0;
    logic [127:0] req_data = '0;
    logic         rsp_ready = 1'b0, rcv = 1'b0, done = 1'b0;
    logic [127:0] cdata = '0;

    logic         o_req_ready, o_rsp_valid, o_rsp_we, o_en, o_we, o_ack, o_busy, o_timeout;
    logic [22:0]  o_addr;
    logic [15:0]  o_strb;
    logic [127:0] o_rsp_data, o_data;

    memory_requester #(.TIMEOUT_CYCLES(TO), .CNT_W(16)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_req_valid(req_valid), .o_req_ready(o_req_ready), .i_req_we(req_we),
        .i_req_addr(req_addr), .i_req_strb(req_strb), .i_req_data(req_data),
        .o_rsp_valid(o_rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_we(o_rsp_we),
        .o_rsp_data(o_rsp_data), .o_en(o_en), .o_we(o_we), .o_addr(o_addr),
        .o_strb(o_strb), .o_data(o_data), .i_rcv(rcv), .i_done(done), .i_data(cdata),
        .o_ack(o_ack), .o_busy(o_busy), .o_timeout(o_timeout)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: each transaction is the edge index at which every
    // handshake event was sampled; outputs are intervals between those edges.
    int cyc = 0;
    bit started = 1'b0;
    int t_launch = INF, t_rcv = INF, t_rcv_low = INF, t_done = INF, t_done_low = INF;
    int t_rsp = INF, t_ret = INF;
    logic         m_we = 0, m_rsp_we = 0, m_timeout = 0;
    logic [22:0]  m_addr = '0;
    logic [15:0]  m_strb = '0;
    logic [127:0] m_data = '0, m_rsp_data = '0;

    function automatic bit m_busy();
        return (t_launch <= cyc) && (cyc < t_ret);
    endfunction

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (rst) begin
            started = 1'b1;
            t_launch = INF; t_rcv = INF; t_rcv_low = INF; t_done = INF;
            t_done_low = INF; t_rsp = INF; t_ret = INF;
            m_we = 0; m_addr = '0; m_strb = '0; m_data = '0;
            m_rsp_we = 0; m_rsp_data = '0; m_timeout = 0;
        end else if (!(t_launch != INF && t_ret == INF)) begin
            if (req_valid) begin
                t_launch = cyc; t_rcv = INF; t_rcv_low = INF; t_done = INF;
                t_done_low = INF; t_rsp = INF; t_ret = INF;
                m_we = req_we; m_addr = req_addr; m_strb = req_strb; m_data = req_data;
            end
        end else begin
            if (t_rcv == INF && rcv) t_rcv = cyc;
            else if (t_rcv != INF && t_rcv_low == INF && !rcv) t_rcv_low = cyc;
            if (t_done == INF && done) begin
                t_done = cyc;
                m_rsp_data = cdata;
            end else if (t_done != INF && t_done_low == INF && !done) t_done_low = cyc;
            if (TO != 0 && cyc - t_launch == TO && t_done >= cyc) m_timeout = 1;
            if (t_rsp == INF && t_rcv_low != INF && t_done_low != INF) begin
                t_rsp = cyc;
                m_rsp_we = m_we;
            end else if (t_rsp != INF && t_ret == INF && rsp_ready) t_ret = cyc;
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("req_ready", o_req_ready, !m_busy());
            chk("busy",      o_busy,      m_busy());
            chk("en",        o_en,        (t_launch <= cyc) && (cyc < t_rcv));
            chk("ack",       o_ack,       (t_done <= cyc) && (cyc < t_done_low));
            chk("rsp_valid", o_rsp_valid, (t_rsp <= cyc) && (cyc < t_ret));
            chk("we",        o_we,        m_we);
            chk("addr",      o_addr,      m_addr);
            chk("strb",      o_strb,      m_strb);
            chk("data",      o_data,      m_data);
            chk("rsp_we",    o_rsp_we,    m_rsp_we);
            chk("rsp_data",  o_rsp_data,  m_rsp_data);
            chk("timeout",   o_timeout,   m_timeout);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic we, input logic [22:0] a, input logic [15:0] s,
                         input logic [127:0] d);
        req_valid = 1'b1; req_we = we; req_addr = a; req_strb = s; req_data = d;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic rand_txn();
        int d_rcv, l_rcv, d_done, l_done, span;
        issue(1'($urandom_range(0, 1)), 23'($urandom), 16'($urandom),
              {$urandom, $urandom, $urandom, $urandom});
        d_rcv  = $urandom_range(0, 4);
        l_rcv  = $urandom_range(1, 3);
        d_done = $urandom_range(0, 12);
        l_done = $urandom_range(1, 3);
        span   = ((d_rcv + l_rcv) > (d_done + l_done)) ? d_rcv + l_rcv : d_done + l_done;
        for (int k = 0; k <= span; k++) begin
            rcv       = (k >= d_rcv) && (k < d_rcv + l_rcv);
            done      = (k >= d_done) && (k < d_done + l_done);
            cdata     = {$urandom, $urandom, $urandom, $urandom};
            rsp_ready = 1'($urandom_range(0, 1));
            tick();
        end
        rcv = 1'b0;
        done = 1'b0;
        for (int g = 0; g < 64 && m_busy(); g++) begin
            rsp_ready = ($urandom_range(0, 3) == 0);
            req_valid = 1'($urandom_range(0, 1));
            req_addr  = 23'($urandom);
            cdata     = {$urandom, $urandom, $urandom, $urandom};
            tick();
        end
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        checks++;
        if (m_busy()) begin
            failures++;
            $display("FAIL txn_complete: transaction still open after cycle budget (t=%0t)", $time);
        end
        repeat ($urandom_range(0, 2)) tick();
    endtask

    localparam logic [127:0] RD_LINE = 128'hDEAD_0000_1111_2222_3333_4444_5555_BEEF;
    localparam logic [127:0] WR_LINE = 128'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF;
    localparam logic [127:0] WR_RSP  = 128'hA5A5_5A5A_A5A5_5A5A_A5A5_5A5A_A5A5_5A5A;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) tick();
        chk("rst_req_ready", o_req_ready, 1'b1);
        chk("rst_en", o_en, 1'b0);
        chk("rst_rsp_data", o_rsp_data, 128'h0);
        rst = 1'b0;
        tick();

        // Read with i_done arriving while i_rcv is still high.
        issue(1'b0, 23'h00ABC, 16'hFFFF, 128'h0);
        chk("rd_en_on", o_en, 1'b1);
        chk("rd_addr", o_addr, 23'h00ABC);
        chk("rd_not_ready", o_req_ready, 1'b0);
        tick(); tick();
        rcv = 1'b1;
        tick();
        chk("rd_en_off", o_en, 1'b0);
        done = 1'b1; cdata = RD_LINE;
        tick();
        chk("rd_ack_on", o_ack, 1'b1);
        chk("rd_capture", o_rsp_data, RD_LINE);
        chk("model_capture", m_rsp_data, RD_LINE);
        rcv = 1'b0; cdata = 128'h0;
        tick();
        chk("rd_no_rsp_while_done", o_rsp_valid, 1'b0);
        done = 1'b0;
        tick();
        chk("rd_ack_off", o_ack, 1'b0);
        chk("rd_rsp_valid", o_rsp_valid, 1'b1);
        chk("rd_rsp_we", o_rsp_we, 1'b0);
        for (int i = 0; i < 10; i++) begin
            req_valid = 1'b1;
            tick();
            chk("bp_rsp_valid", o_rsp_valid, 1'b1);
            chk("bp_rsp_data", o_rsp_data, RD_LINE);
            chk("bp_not_ready", o_req_ready, 1'b0);
        end
        req_valid = 1'b0; rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("rd_released", o_rsp_valid, 1'b0);
        chk("rd_idle", o_busy, 1'b0);

        // Write with i_rcv and i_done in the same cycle.
        issue(1'b1, 23'h12345, 16'h00FF, WR_LINE);
        for (int i = 0; i < 3; i++) begin
            chk("wr_strb", o_strb, 16'h00FF);
            chk("wr_data", o_data, WR_LINE);
            chk("wr_en_held", o_en, 1'b1);
            tick();
        end
        rcv = 1'b1; done = 1'b1; cdata = WR_RSP;
        tick();
        chk("wr_en_off", o_en, 1'b0);
        chk("wr_ack_on", o_ack, 1'b1);
        rcv = 1'b0; done = 1'b0;
        tick();
        chk("wr_rsp_valid", o_rsp_valid, 1'b1);
        chk("wr_rsp_we", o_rsp_we, 1'b1);
        chk("wr_rsp_data", o_rsp_data, WR_RSP);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("wr_idle", o_busy, 1'b0);

        // Timeout: i_done withheld past TO cycles after launch.
        issue(1'b0, 23'h00001, 16'hFFFF, 128'h0);
        for (int i = 1; i < TO; i++) begin
            rcv = (i == 1);
            tick();
            chk("to_not_yet", o_timeout, 1'b0);
        end
        tick();
        chk("to_set", o_timeout, 1'b1);
        chk("model_to_set", m_timeout, 1'b1);
        done = 1'b1;
        tick();
        done = 1'b0;
        tick();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("to_completed", o_busy, 1'b0);
        chk("to_sticky", o_timeout, 1'b1);

        for (int n = 0; n < 120; n++) rand_txn();

        // Reset while in WAIT with o_ack high.
        issue(1'b1, 23'h7FFFF, 16'hF0F0, WR_LINE);
        rcv = 1'b1; done = 1'b1; cdata = WR_RSP;
        tick();
        tick();
        chk("rstw_ack_high", o_ack, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0; rcv = 1'b0; done = 1'b0;
        chk("rstw_ack", o_ack, 1'b0);
        chk("rstw_en", o_en, 1'b0);
        chk("rstw_rsp_valid", o_rsp_valid, 1'b0);
        chk("rstw_ready", o_req_ready, 1'b1);
        chk("rstw_timeout", o_timeout, 1'b0);
        tick();

        for (int n = 0; n < 40; n++) rand_txn();

        repeat (2) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
